// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the bit-serial shift-and-add multiplier.
// Optional feature macro: SEQ_MUL_EARLY_TERM_EN (early termination).
package seq_mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Iteration counter width for an N-bit operand: enough to hold 0..N.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Operand/result bus between the operand registers and the multiplier.
interface seq_mul_if #(parameter int N = 8);
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (output start, signed_mode, a, b, input busy, done, product);
  modport slave  (input start, signed_mode, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mul_dp.sv
// Multiplier datapath: M/acc/Q registers, add/sub and the {acc,Q} shifter.
// With SEQ_MUL_EARLY_TERM_EN it also tracks the unprocessed multiplier bits
// and aligns a truncated result.
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           last,
  input  logic           sgn,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef SEQ_MUL_EARLY_TERM_EN
  input  logic [cw_of(N)-1:0] cnt,
  output logic           rem_zero,
`endif
  output logic [2*N-1:0] res
);
  localparam int CW = cw_of(N);

  logic [N-1:0] m, q, q_n;
  logic [N:0]   acc, acc_n, ext, addend;
  logic [N+1:0] acc_x, add_x, sum;
  logic         sgn_r, sub, shin;

  // One add/subtract step followed by a one-bit right shift of {acc,Q}.
  always_comb begin
    ext    = sgn_r ? {m[N-1], m} : {1'b0, m};
    addend = q[0] ? ext : '0;
    // Last step of a signed multiply weights the multiplier MSB negatively.
    sub    = sgn_r & last & q[0];
    acc_x  = {sgn_r & acc[N], acc};
    add_x  = {sgn_r & addend[N], addend};
    sum    = sub ? (acc_x - add_x) : (acc_x + add_x);
    shin   = sgn_r ? sum[N] : sum[N+1];
    acc_n  = {shin, sum[N:1]};
    q_n    = {sum[0], q[N-1:1]};
  end

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [N-1:0]   r;
  logic [CW-1:0]  sh;
  logic [2*N:0]   wide, shr;

  // After this step the unprocessed bits are r[N-1:1]; align {acc,Q} by
  // the steps that will be skipped.
  always_comb begin
    rem_zero = ~|r[N-1:1];
    sh       = CW'(N - 1) - cnt;
    wide     = {acc_n, q_n};
    if (sgn_r) shr = $signed(wide) >>> sh;
    else       shr = wide >> sh;
    res      = shr[2*N-1:0];
  end

  // Shadow of the multiplier with zero fill, used only to detect early exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r <= '0;
    else if (load) r <= b;
    else if (step) r <= r >> 1;
  end
`else
  // Full-length result after the final step.
  always_comb res = {acc_n[N-1:0], q_n};
`endif

  // Operand latch on accept, shift/accumulate on every RUN step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '0; q <= '0; acc <= '0; sgn_r <= 1'b0;
    end else if (load) begin
      m <= a; q <= b; acc <= '0; sgn_r <= sgn;
    end else if (step) begin
      q <= q_n; acc <= acc_n;
    end
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Bit-serial shift-and-add multiplier: FSM, iteration counter, product/done.
// Optional feature macro: SEQ_MUL_EARLY_TERM_EN (stop once the remaining
// multiplier bits are all zero).
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic     clk,
  input  logic     reset,
  seq_mul_if.slave bus
);
  localparam int CW = cw_of(N);

  state_t         state, nxt;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] product, res;
  logic           load, step, last, cap, fin;

  assign last = (cnt == CW'(N - 1));

  seq_mul_dp #(.N(N)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .last     (last),
    .sgn      (bus.signed_mode),
    .a        (bus.a),
    .b        (bus.b),
`ifdef SEQ_MUL_EARLY_TERM_EN
    .cnt      (cnt),
    .rem_zero (fin),
`endif
    .res      (res)
  );

`ifndef SEQ_MUL_EARLY_TERM_EN
  assign fin = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state and datapath controls; start is only honoured in IDLE/DONE.
  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    cap  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin load = 1'b1; nxt = RUN; end
      RUN: begin
        step = 1'b1;
        if (last || fin) begin cap = 1'b1; nxt = DONE; end
      end
      DONE: begin
        if (bus.start) begin load = 1'b1; nxt = RUN; end
        else           nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Iteration counter: cleared on accept, advanced each RUN step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + 1'b1;
  end

  // Product is captured only on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    product <= '0;
    else if (cap) product <= res;
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed-vector bench for seq_mul_unit (N=8).
module tb_seq_mul_unit;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_mul_if #(.N(N)) bus ();

  seq_mul_unit #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected RUN cycles for multiplier b.
  function automatic int exp_lat(input logic [7:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < N; i++) if (b[i]) h = i;
    return h + 1;
`else
    return N;
`endif
  endfunction

  // Present an operation and return #1 after the accepting edge.
  task automatic go(input logic s, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    bus.start = 1'b1; bus.signed_mode = s; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called #1 after the accepting edge; checks latency, busy length, product.
  task automatic wait_done(input string tag, input int lat, input logic [15:0] prod);
    int  cyc, bcnt;
    bit  seen;
    cyc = 0; bcnt = 0; seen = 0;
    if (bus.busy) bcnt++;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) seen = 1;
      else if (bus.busy) bcnt++;
    end
    chk({tag, "_lat"},  cyc,  lat);
    chk({tag, "_busy"}, bcnt, lat);
    chk({tag, "_prod"}, bus.product, prod);
  endtask

  initial begin
    int dn;
    reset = 1'b1;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_prod", bus.product, 0);
    @(negedge clk) reset = 1'b0;

    // Unsigned 13 x 11 = 143.
    go(0, 8'd13, 8'd11);
    wait_done("u13x11", exp_lat(8'd11), 16'h008F);

    // Signed -3 x 5 = -15; -128 x -128 = 16384.
    go(1, 8'hFD, 8'd5);
    wait_done("s_m3x5", exp_lat(8'd5), 16'hFFF1);
    go(1, 8'h80, 8'h80);
    wait_done("s_min2", exp_lat(8'h80), 16'h4000);

    // Unsigned max x max, then back-to-back 2 x 3 accepted in DONE.
    go(0, 8'hFF, 8'hFF);
    wait_done("u_max", exp_lat(8'hFF), 16'hFE01);
    bus.start = 1'b1; bus.a = 8'd2; bus.b = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_run", bus.busy, 1);
    chk("b2b_hold", bus.product, 16'hFE01);
    wait_done("b2b", exp_lat(8'd3), 16'h0006);

    // start pulsed during RUN must be ignored.
    go(0, 8'd13, 8'd11);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd99;
    @(negedge clk);
    bus.start = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("ign_done_cnt", dn, 1);
    chk("ign_prod", bus.product, 16'h008F);

    // Reset in the middle of an operation aborts it.
    go(0, 8'd200, 8'd201);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_prod", bus.product, 0);
    @(negedge clk) reset = 1'b0;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("abort_no_done", dn, 0);

    // Zero operand, short and long multipliers.
    go(0, 8'd0, 8'd77);
    wait_done("zero_a", exp_lat(8'd77), 16'h0000);
    go(0, 8'd3, 8'd1);
    wait_done("u3x1", exp_lat(8'd1), 16'h0003);
    go(0, 8'd3, 8'h80);
    wait_done("u3x128", exp_lat(8'h80), 16'h0180);
    go(1, 8'hFD, 8'hFB);
    wait_done("s_m3xm5", exp_lat(8'hFB), 16'h000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
